// File: rtl/fabric_cfg_loader.sv
// Configuration sequencer: packs IN_W stream words into CFG_W rows and strobes them into the fabric.
// Optional CFG_CHECKSUM_EN: an XOR trailer word follows the last row; a mismatch parks in ERROR.
module fabric_cfg_loader #(
  parameter int CFG_W      = 384,
  parameter int NUM_ROWS   = 267,
  parameter int IN_W       = 32,
  parameter int SETTLE_CYC = 10
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_W-1:0]     s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [CFG_W-1:0]    configs_in,
  output logic [NUM_ROWS-1:0] configs_en,
  output logic                ff_en,
  output logic                rdy,
  output logic                busy,
  output logic                err
);

  localparam int WPR = CFG_W / IN_W;
  localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [WCW-1:0] LAST_WORD   = WCW'(WPR - 1);
  localparam logic [RW-1:0]  LAST_ROW    = RW'(NUM_ROWS - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, STROBE, SETTLE, ARM, DONE
`ifdef CFG_CHECKSUM_EN
    , ERROR
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                s_ready_q, s_ready_d;
  logic [CFG_W-1:0]    configs_in_q, configs_in_d;
  logic [NUM_ROWS-1:0] configs_en_q, configs_en_d;
  logic                ff_en_q, ff_en_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [WCW-1:0]      word_cnt_q, word_cnt_d;
  logic [RW-1:0]       row_q, row_d;
  logic [SCW-1:0]      settle_q, settle_d;
  logic [CFG_W-1:0]    asm_q, asm_d;
`ifdef CFG_CHECKSUM_EN
  logic [IN_W-1:0]     xor_q, xor_d;
  logic                trailer_q, trailer_d;
`endif
  logic                accept;
  logic                go;
  logic [CFG_W-1:0]    asm_ins;

  always_comb begin
    state_d      = state_q;
    s_ready_d    = s_ready_q;
    configs_in_d = configs_in_q;
    configs_en_d = '0;
    ff_en_d      = ff_en_q;
    rdy_d        = rdy_q;
    busy_d       = busy_q;
    err_d        = err_q;
    word_cnt_d   = word_cnt_q;
    row_d        = row_q;
    settle_d     = settle_q;
    asm_d        = asm_q;
`ifdef CFG_CHECKSUM_EN
    xor_d        = xor_q;
    trailer_d    = trailer_q;
`endif
    go           = 1'b0;
    accept       = s_valid & s_ready_q;
    asm_ins      = asm_q;
    asm_ins[int'(word_cnt_q)*IN_W +: IN_W] = s_data;

    case (state_q)
      IDLE: go = start;
      LOAD: begin
        if (accept) begin
          asm_d = asm_ins;
          if (word_cnt_q == LAST_WORD) begin
            configs_in_d = asm_ins;
            s_ready_d    = 1'b0;
            word_cnt_d   = '0;
            state_d      = SETUP;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
`ifdef CFG_CHECKSUM_EN
          xor_d = xor_q ^ s_data;
          // The trailer is compared, never packed into a row.
          if (trailer_q) begin
            asm_d        = asm_q;
            word_cnt_d   = word_cnt_q;
            configs_in_d = configs_in_q;
            s_ready_d    = 1'b0;
            if (s_data == xor_q) begin
              state_d  = SETTLE;
              settle_d = SETTLE_LAST;
            end else begin
              state_d = ERROR;
              err_d   = 1'b1;
              busy_d  = 1'b0;
            end
          end
`endif
        end
      end
      SETUP: begin
        configs_en_d = NUM_ROWS'(1) << row_q;
        state_d      = STROBE;
      end
      STROBE: begin
        if (row_q == LAST_ROW) begin
          row_d = '0;
`ifdef CFG_CHECKSUM_EN
          state_d   = LOAD;
          trailer_d = 1'b1;
          s_ready_d = 1'b1;
`else
          state_d  = SETTLE;
          settle_d = SETTLE_LAST;
`endif
        end else begin
          row_d     = row_q + RW'(1);
          state_d   = LOAD;
          s_ready_d = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          ff_en_d  = 1'b1;
          settle_d = SETTLE_LAST;
          state_d  = ARM;
        end else begin
          settle_d = settle_q - SCW'(1);
        end
      end
      ARM: begin
        if (settle_q == '0) begin
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          settle_d = settle_q - SCW'(1);
        end
      end
      DONE: go = start;
`ifdef CFG_CHECKSUM_EN
      ERROR: go = start;
`endif
      default: state_d = IDLE;
    endcase

    if (go) begin
      state_d    = LOAD;
      s_ready_d  = 1'b1;
      busy_d     = 1'b1;
      ff_en_d    = 1'b0;
      rdy_d      = 1'b0;
      err_d      = 1'b0;
      word_cnt_d = '0;
      row_d      = '0;
`ifdef CFG_CHECKSUM_EN
      xor_d      = '0;
      trailer_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      s_ready_q    <= 1'b0;
      configs_in_q <= '0;
      configs_en_q <= '0;
      ff_en_q      <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      word_cnt_q   <= '0;
      row_q        <= '0;
      settle_q     <= '0;
      asm_q        <= '0;
`ifdef CFG_CHECKSUM_EN
      xor_q        <= '0;
      trailer_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      configs_in_q <= configs_in_d;
      configs_en_q <= configs_en_d;
      ff_en_q      <= ff_en_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      word_cnt_q   <= word_cnt_d;
      row_q        <= row_d;
      settle_q     <= settle_d;
      asm_q        <= asm_d;
`ifdef CFG_CHECKSUM_EN
      xor_q        <= xor_d;
      trailer_q    <= trailer_d;
`endif
    end
  end

  assign s_ready    = s_ready_q;
  assign configs_in = configs_in_q;
  assign configs_en = configs_en_q;
  assign ff_en      = ff_en_q;
  assign rdy        = rdy_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Bench for fabric_cfg_loader: small geometry (64-bit rows of two 32-bit words, 3 rows) plus a one-word-per-row instance.
// Honours CFG_CHECKSUM_EN by appending the XOR trailer to every stream.
module tb_fabric_cfg_loader;
  localparam int CFG_W = 64;
  localparam int IN_W = 32;
  localparam int NUM_ROWS = 3;
  localparam int SETTLE_CYC = 4;
  localparam int WPR = CFG_W / IN_W;
  localparam int ND = NUM_ROWS * WPR;
`ifdef CFG_CHECKSUM_EN
  localparam int NW = ND + 1;
`else
  localparam int NW = ND;
`endif

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic [IN_W-1:0] s_data = '0;
  logic s_ready, ff_en, rdy, busy, err;
  logic [CFG_W-1:0] configs_in;
  logic [NUM_ROWS-1:0] configs_en;

  logic start2 = 1'b0;
  logic s_valid2 = 1'b0;
  logic [63:0] s_data2 = '0;
  logic s_ready2, ff_en2, rdy2, busy2, err2;
  logic [63:0] configs_in2;
  logic [2:0] configs_en2;

  always #5 clock = ~clock;

  fabric_cfg_loader #(.CFG_W(CFG_W), .NUM_ROWS(NUM_ROWS), .IN_W(IN_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clock(clock), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .configs_in(configs_in), .configs_en(configs_en), .ff_en(ff_en), .rdy(rdy), .busy(busy), .err(err));

  fabric_cfg_loader #(.CFG_W(64), .NUM_ROWS(3), .IN_W(64), .SETTLE_CYC(4)) dut_w1 (
    .clock(clock), .rst(rst), .start(start2), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .configs_in(configs_in2), .configs_en(configs_en2), .ff_en(ff_en2), .rdy(rdy2), .busy(busy2), .err(err2));

  int checks = 0;
  int errors = 0;

  logic [IN_W-1:0] words [NW+4];
  logic [NUM_ROWS-1:0] ob_en [$];
  logic [CFG_W-1:0] ob_data [$];
  int ob_cyc [$];
  int n_setup_bad, n_multi, n_acc, n_busy_bad, ref_cyc, ff_cyc, rdy_cyc;
  bit timed_out, got_err;
  logic f_ff, f_rdy, f_busy, f_err, busy_end, ff_end, rdy_end;

  // Stream = ND row words, then (checksum build) their XOR, then junk that must never be taken.
  function automatic void gen_words(input bit fixed);
    logic [IN_W-1:0] x;
    x = '0;
    for (int i = 0; i < NW + 4; i++) words[i] = IN_W'($urandom);
    for (int i = 0; i < ND; i++) begin
      words[i] = fixed ? IN_W'((i + 1) * 17) : IN_W'($urandom);
      x ^= words[i];
    end
    words[ND] = x;
  endfunction

  function automatic logic [CFG_W-1:0] exp_row(input int r);
    logic [CFG_W-1:0] v;
    v = '0;
    for (int k = 0; k < WPR; k++) v[k*IN_W +: IN_W] = words[r*WPR + k];
    return v;
  endfunction

  function automatic logic [NUM_ROWS-1:0] exp_en(input int r);
    logic [NUM_ROWS-1:0] e;
    e = '0;
    e[r] = 1'b1;
    return e;
  endfunction

  task automatic run_load(input bit bp, input bit mid_start);
    int idx = 0;
    logic [NUM_ROWS-1:0] prev_en;
    logic [CFG_W-1:0] prev_data;
    ob_en.delete(); ob_data.delete(); ob_cyc.delete();
    n_setup_bad = 0; n_multi = 0; n_acc = 0; n_busy_bad = 0;
    ref_cyc = -1; ff_cyc = -1; rdy_cyc = -1; timed_out = 1'b1; got_err = 1'b0;
    prev_en = configs_en; prev_data = configs_in;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      if (c == 1) begin f_ff = ff_en; f_rdy = rdy; f_busy = busy; f_err = err; end
      if (configs_en != '0) begin
        ob_en.push_back(configs_en); ob_data.push_back(configs_in); ob_cyc.push_back(c);
        if ($countones(configs_en) != 1) n_multi++;
        if (prev_en != '0 || prev_data !== configs_in) n_setup_bad++;
        ref_cyc = c;
      end
      if (c >= 1 && ff_en && ff_cyc < 0) ff_cyc = c;
      if (c >= 1 && (rdy || err)) begin
        rdy_cyc = rdy ? c : -1; got_err = err; busy_end = busy; ff_end = ff_en; rdy_end = rdy;
        timed_out = 1'b0;
        break;
      end
      if (c >= 1 && !busy) n_busy_bad++;
      prev_en = configs_en; prev_data = configs_in;
      start = (c == 0) || (mid_start && c == 4);
      s_valid = bp ? (c % 2 == 0) : 1'b1;
      s_data = words[idx];
      if (s_valid && s_ready) begin
        n_acc++;
        if (idx == NW - 1) ref_cyc = c;
        if (idx < NW + 3) idx++;
      end
    end
    start = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    checks++; if (configs_in !== '0) begin errors++; $display("FAIL reset_configs_in: got %h expected 0", configs_in); end
    checks++; if (configs_en !== '0) begin errors++; $display("FAIL reset_configs_en: got %b expected 0", configs_en); end
    checks++; if ({ff_en, rdy, busy, err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {ff_en, rdy, busy, err}); end
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic(input bit fixed, input bit bp);
    gen_words(fixed);
    run_load(bp, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL load_timeout: got timeout expected rdy (fixed=%0d bp=%0d)", fixed, bp); end
    checks++; if (ob_en.size() != NUM_ROWS) begin errors++; $display("FAIL strobe_count: got %0d expected %0d", ob_en.size(), NUM_ROWS); end
    if (ob_en.size() == NUM_ROWS) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        checks++; if (ob_en[r] !== exp_en(r)) begin errors++; $display("FAIL strobe_en row %0d: got %b expected %b", r, ob_en[r], exp_en(r)); end
        checks++; if (ob_data[r] !== exp_row(r)) begin errors++; $display("FAIL row_data row %0d: got %h expected %h", r, ob_data[r], exp_row(r)); end
        if (!bp && r > 0) begin
          checks++; if (ob_cyc[r] - ob_cyc[r-1] != WPR + 2) begin errors++; $display("FAIL row_latency row %0d: got %0d expected %0d", r, ob_cyc[r] - ob_cyc[r-1], WPR + 2); end
        end
      end
    end
    checks++; if (n_multi != 0 || n_setup_bad != 0) begin errors++; $display("FAIL strobe_shape: got multi=%0d setup_bad=%0d expected 0/0", n_multi, n_setup_bad); end
    checks++; if (n_acc != NW) begin errors++; $display("FAIL words_accepted: got %0d expected %0d", n_acc, NW); end
    checks++; if (ff_cyc - ref_cyc != SETTLE_CYC + 1) begin errors++; $display("FAIL ff_en_delay: got %0d expected %0d", ff_cyc - ref_cyc, SETTLE_CYC + 1); end
    checks++; if (rdy_cyc - ff_cyc != SETTLE_CYC) begin errors++; $display("FAIL rdy_delay: got %0d expected %0d", rdy_cyc - ff_cyc, SETTLE_CYC); end
    checks++; if (got_err || busy_end || n_busy_bad != 0) begin errors++; $display("FAIL busy_err: got err=%b busy_end=%b busy_gaps=%0d expected 0/0/0", got_err, busy_end, n_busy_bad); end
  endtask

  task automatic test_restart();
    gen_words(1'b0);
    run_load(1'b0, 1'b1);
    checks++; if ({f_ff, f_rdy, f_busy} !== 3'b001) begin errors++; $display("FAIL restart_edge: got ff/rdy/busy=%b expected 001", {f_ff, f_rdy, f_busy}); end
    checks++; if (timed_out || rdy_cyc < 0) begin errors++; $display("FAIL restart_done: got rdy_cyc=%0d expected completion", rdy_cyc); end
    checks++; if (ob_en.size() != NUM_ROWS) begin errors++; $display("FAIL restart_strobes: got %0d expected %0d", ob_en.size(), NUM_ROWS); end
    if (ob_en.size() == NUM_ROWS)
      for (int r = 0; r < NUM_ROWS; r++) begin
        checks++; if (ob_data[r] !== exp_row(r) || ob_en[r] !== exp_en(r)) begin errors++; $display("FAIL restart_row %0d: got %h/%b expected %h/%b", r, ob_data[r], ob_en[r], exp_row(r), exp_en(r)); end
      end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    int quiet = 0;
    bit hit = 1'b0;
    gen_words(1'b0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (configs_en == NUM_ROWS'(2)) begin hit = 1'b1; break; end
      start = (c == 0); s_valid = 1'b1; s_data = words[idx];
      if (s_valid && s_ready && idx < NW + 3) idx++;
    end
    checks++; if (!hit) begin errors++; $display("FAIL midrst_reach: got no row-1 strobe expected one"); end
    rst = 1'b1; start = 1'b0;
    @(negedge clock);
    checks++; if ({s_ready, configs_in, configs_en, ff_en, rdy, busy, err} !== '0) begin errors++; $display("FAIL midrst_outputs: got ready=%b data=%h en=%b flags=%b expected all 0", s_ready, configs_in, configs_en, {ff_en, rdy, busy, err}); end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (s_ready || configs_en != '0 || busy) quiet++;
    end
    s_valid = 1'b0;
    checks++; if (quiet != 0) begin errors++; $display("FAIL midrst_idle: got %0d active cycles expected 0", quiet); end
    gen_words(1'b0);
    run_load(1'b0, 1'b0);
    checks++; if (ob_en.size() != NUM_ROWS || timed_out) begin errors++; $display("FAIL midrst_reload: got %0d strobes timeout=%b expected %0d/0", ob_en.size(), timed_out, NUM_ROWS); end
    if (ob_en.size() == NUM_ROWS)
      for (int r = 0; r < NUM_ROWS; r++) begin
        checks++; if (ob_data[r] !== exp_row(r) || ob_en[r] !== exp_en(r)) begin errors++; $display("FAIL midrst_row %0d: got %h/%b expected %h/%b", r, ob_data[r], ob_en[r], exp_row(r), exp_en(r)); end
      end
  endtask

`ifdef CFG_CHECKSUM_EN
  task automatic test_checksum();
    gen_words(1'b1);
    words[ND] = words[ND] + IN_W'(1);
    run_load(1'b0, 1'b0);
    checks++; if (timed_out || !got_err) begin errors++; $display("FAIL cksum_bad_err: got err=%b timeout=%b expected 1/0", got_err, timed_out); end
    checks++; if ({ff_end, rdy_end, busy_end} !== 3'b000) begin errors++; $display("FAIL cksum_bad_flags: got ff/rdy/busy=%b expected 000", {ff_end, rdy_end, busy_end}); end
    gen_words(1'b1);
    run_load(1'b0, 1'b0);
    checks++; if (f_err !== 1'b0) begin errors++; $display("FAIL cksum_err_clear: got %b expected 0", f_err); end
    checks++; if (timed_out || got_err || rdy_cyc < 0) begin errors++; $display("FAIL cksum_good: got err=%b rdy_cyc=%0d expected completion", got_err, rdy_cyc); end
  endtask
`endif

  task automatic test_wpr1();
    logic [63:0] w2 [4];
    logic [63:0] got_d [$];
    logic [2:0] got_e [$];
    int got_c [$];
    logic [2:0] pe;
    logic [63:0] pd;
    logic [2:0] e;
    int idx = 0;
    int bad = 0;
    bit done = 1'b0;
    w2[3] = '0;
    for (int i = 0; i < 3; i++) begin w2[i] = {$urandom, $urandom}; w2[3] ^= w2[i]; end
    pe = configs_en2; pd = configs_in2;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (c >= 1 && rdy2) begin done = 1'b1; break; end
      if (configs_en2 != '0) begin
        got_d.push_back(configs_in2); got_e.push_back(configs_en2); got_c.push_back(c);
        if (pe != '0 || pd !== configs_in2) bad++;
      end
      pe = configs_en2; pd = configs_in2;
      start2 = (c == 0); s_valid2 = 1'b1; s_data2 = w2[idx];
      if (s_valid2 && s_ready2 && idx < 3) idx++;
    end
    start2 = 1'b0; s_valid2 = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL wpr1_done: got timeout expected rdy"); end
    checks++; if (got_e.size() != 3 || bad != 0) begin errors++; $display("FAIL wpr1_strobes: got %0d strobes setup_bad=%0d expected 3/0", got_e.size(), bad); end
    if (got_e.size() == 3)
      for (int r = 0; r < 3; r++) begin
        e = '0; e[r] = 1'b1;
        checks++; if (got_d[r] !== w2[r] || got_e[r] !== e) begin errors++; $display("FAIL wpr1_row %0d: got %h/%b expected %h/%b", r, got_d[r], got_e[r], w2[r], e); end
        if (r > 0) begin
          checks++; if (got_c[r] - got_c[r-1] != 3) begin errors++; $display("FAIL wpr1_rate row %0d: got %0d expected 3", r, got_c[r] - got_c[r-1]); end
        end
      end
  endtask

  initial begin
    test_reset();
    test_basic(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) test_basic(1'b0, 1'b0);
    test_basic(1'b1, 1'b1);
    test_basic(1'b0, 1'b1);
    test_restart();
    test_reset_mid();
`ifdef CFG_CHECKSUM_EN
    test_checksum();
`endif
    test_wpr1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
